// File: rtl/control_unit_pkg.sv
// ------------------------------------------------------------------
// cpu_ctrl_pkg : shared encodings and the idle control vector
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package cpu_ctrl_pkg;

  localparam logic [5:0] c_op_bra  = 6'h00;
  localparam logic [5:0] c_op_bne  = 6'h01;
  localparam logic [5:0] c_op_beq  = 6'h02;
  localparam logic [5:0] c_op_movl = 6'h03;
  localparam logic [5:0] c_op_add  = 6'h04;
  localparam logic [5:0] c_op_sub  = 6'h05;
  localparam logic [5:0] c_op_and  = 6'h06;
  localparam logic [5:0] c_op_ld   = 6'h07;
  localparam logic [5:0] c_op_st   = 6'h08;

  localparam logic [4:0] c_alu_passa = 5'b00000;
  localparam logic [4:0] c_alu_add   = 5'b00100;
  localparam logic [4:0] c_alu_sub   = 5'b00110;
  localparam logic [4:0] c_alu_and   = 5'b00111;

  localparam logic [2:0] c_rf_fun_load   = 3'b010;
  localparam logic [1:0] c_arf_fun_load  = 2'b10;
  localparam logic [1:0] c_arf_fun_inc   = 2'b01;
  localparam logic [1:0] c_dr_fun_clr_ll = 2'b01;

  localparam logic [1:0] c_arf_out_pc = 2'b00;
  localparam logic [1:0] c_arf_out_ar = 2'b10;
  localparam logic [2:0] c_arf_reg_pc = 3'b100;

  localparam logic [1:0] c_muxa_alu = 2'b00;
  localparam logic [1:0] c_muxa_dr  = 2'b10;
  localparam logic [1:0] c_muxa_imm = 2'b11;
  localparam logic [1:0] c_muxb_imm = 2'b11;
  localparam logic [1:0] c_muxc_alu = 2'b00;

  typedef enum logic [3:0] {
    ST_T0 = 4'b0001,
    ST_T1 = 4'b0010,
    ST_T2 = 4'b0100,
    ST_T3 = 4'b1000
  } seq_state_t;

  typedef struct packed {
    logic       alu_wf;
    logic [4:0] alu_fun_sel;
    logic [2:0] rf_out_a_sel;
    logic [2:0] rf_out_b_sel;
    logic [2:0] rf_fun_sel;
    logic [3:0] rf_reg_sel;
    logic [3:0] rf_scr_sel;
    logic [1:0] arf_out_c_sel;
    logic [1:0] arf_out_d_sel;
    logic [1:0] arf_fun_sel;
    logic [2:0] arf_reg_sel;
    logic       ir_write;
    logic       ir_lh;
    logic       mem_cs;
    logic       mem_wr;
    logic       dr_e;
    logic [1:0] dr_fun_sel;
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic [1:0] mux_c_sel;
    logic       mux_d_sel;
  } ctrl_t;

  // Chip select is active-low, so the idle vector is not all zeros.
  localparam ctrl_t c_idle = '{mem_cs: 1'b1, default: '0};

  // Register-file write enable for R1..R4, R1 on bit 3.
  function automatic logic [3:0] rf_onehot(input logic [1:0] sel);
    return 4'b1000 >> sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/control_unit_if.sv
// ------------------------------------------------------------------
// control_unit_if : control unit <-> datapath signal bundle
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface control_unit_if;
  logic [15:0] IROut;
  logic [3:0]  Flags;
  logic [3:0]  T;
  logic        ALU_WF;
  logic [4:0]  ALU_FunSel;
  logic [2:0]  RF_OutASel;
  logic [2:0]  RF_OutBSel;
  logic [2:0]  RF_FunSel;
  logic [3:0]  RF_RegSel;
  logic [3:0]  RF_ScrSel;
  logic [1:0]  ARF_OutCSel;
  logic [1:0]  ARF_OutDSel;
  logic [1:0]  ARF_FunSel;
  logic [2:0]  ARF_RegSel;
  logic        IR_Write;
  logic        IR_LH;
  logic        Mem_CS;
  logic        Mem_WR;
  logic        DR_E;
  logic [1:0]  DR_FunSel;
  logic [1:0]  MuxASel;
  logic [1:0]  MuxBSel;
  logic [1:0]  MuxCSel;
  logic        MuxDSel;

  modport master (
    input  IROut, Flags,
    output T, ALU_WF, ALU_FunSel, RF_OutASel, RF_OutBSel, RF_FunSel,
           RF_RegSel, RF_ScrSel, ARF_OutCSel, ARF_OutDSel, ARF_FunSel,
           ARF_RegSel, IR_Write, IR_LH, Mem_CS, Mem_WR, DR_E, DR_FunSel,
           MuxASel, MuxBSel, MuxCSel, MuxDSel
  );

  modport slave (
    output IROut, Flags,
    input  T, ALU_WF, ALU_FunSel, RF_OutASel, RF_OutBSel, RF_FunSel,
           RF_RegSel, RF_ScrSel, ARF_OutCSel, ARF_OutDSel, ARF_FunSel,
           ARF_RegSel, IR_Write, IR_LH, Mem_CS, Mem_WR, DR_E, DR_FunSel,
           MuxASel, MuxBSel, MuxCSel, MuxDSel
  );
endinterface

`default_nettype wire

// File: rtl/control_unit_sequence_counter.sv
// ------------------------------------------------------------------
// sequence_counter : one-hot T0..T3 timing register with clear/advance
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sequence_counter
  import cpu_ctrl_pkg::*;
(
  input  wire        clk,
  input  wire        rst,
  input  wire        i_clr,
  input  wire        i_adv,
  output seq_state_t o_t
);

  seq_state_t r_state;
  seq_state_t w_next;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_T0;
    else     r_state <= w_next;
  end

  // Any value outside the four one-hot codes lands in default and recovers to T0.
  always_comb begin
    w_next = ST_T0;
    if (!i_clr) begin
      case (r_state)
        ST_T0:   w_next = i_adv ? ST_T1 : ST_T0;
        ST_T1:   w_next = i_adv ? ST_T2 : ST_T1;
        ST_T2:   w_next = i_adv ? ST_T3 : ST_T2;
        ST_T3:   w_next = i_adv ? ST_T0 : ST_T3;
        default: w_next = ST_T0;
      endcase
    end
  end

  assign o_t = r_state;

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ------------------------------------------------------------------
// control_unit : hardwired fetch/decode/execute control for the datapath
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module control_unit
  import cpu_ctrl_pkg::*;
(
  input  wire            Clock,
  input  wire            Reset,
  control_unit_if.master bus
);

  seq_state_t w_state;
  ctrl_t      w_ctrl;
  logic       w_end;
  logic [5:0] w_opcode;
  logic [1:0] w_rsel;
  logic [2:0] w_dst;
  logic [2:0] w_s1;
  logic [2:0] w_s2;
  logic       w_regs_ok;
  logic       w_zero;
  logic       w_unused;

  assign w_opcode  = bus.IROut[15:10];
  assign w_rsel    = bus.IROut[9:8];
  assign w_dst     = bus.IROut[8:6];
  assign w_s1      = bus.IROut[5:3];
  assign w_s2      = bus.IROut[2:0];
  assign w_regs_ok = w_dst[2] & w_s1[2] & w_s2[2];
  assign w_zero    = bus.Flags[3];
  assign w_unused  = ^bus.Flags[2:0];

  assign w_end = ((w_state == ST_T2) && (w_opcode != c_op_ld)) || (w_state == ST_T3);

  sequence_counter u_seq (
    .clk   (Clock),
    .rst   (Reset),
    .i_clr (w_end),
    .i_adv (1'b1),
    .o_t   (w_state)
  );

  always_comb begin
    w_ctrl = c_idle;
    if (!Reset) begin
      case (w_state)
        ST_T0, ST_T1: begin
          w_ctrl.arf_out_d_sel = c_arf_out_pc;
          w_ctrl.mem_cs        = 1'b0;
          w_ctrl.ir_write      = 1'b1;
          w_ctrl.ir_lh         = (w_state == ST_T1);
          w_ctrl.arf_reg_sel   = c_arf_reg_pc;
          w_ctrl.arf_fun_sel   = c_arf_fun_inc;
        end
        ST_T2: begin
          case (w_opcode)
            c_op_bra, c_op_bne, c_op_beq: begin
              if ((w_opcode == c_op_bra) ||
                  ((w_opcode == c_op_bne) && !w_zero) ||
                  ((w_opcode == c_op_beq) && w_zero)) begin
                w_ctrl.mux_b_sel   = c_muxb_imm;
                w_ctrl.arf_reg_sel = c_arf_reg_pc;
                w_ctrl.arf_fun_sel = c_arf_fun_load;
              end
            end
            c_op_movl: begin
              w_ctrl.mux_a_sel  = c_muxa_imm;
              w_ctrl.rf_reg_sel = rf_onehot(w_rsel);
              w_ctrl.rf_fun_sel = c_rf_fun_load;
            end
            c_op_add, c_op_sub, c_op_and: begin
              if (w_regs_ok) begin
                w_ctrl.rf_out_a_sel = {1'b0, w_s1[1:0]};
                w_ctrl.rf_out_b_sel = {1'b0, w_s2[1:0]};
                w_ctrl.mux_d_sel    = 1'b0;
                w_ctrl.alu_fun_sel  = (w_opcode == c_op_add) ? c_alu_add :
                                      (w_opcode == c_op_sub) ? c_alu_sub : c_alu_and;
                w_ctrl.alu_wf       = 1'b1;
                w_ctrl.mux_a_sel    = c_muxa_alu;
                w_ctrl.rf_reg_sel   = rf_onehot(w_dst[1:0]);
                w_ctrl.rf_fun_sel   = c_rf_fun_load;
              end
            end
            c_op_ld: begin
              w_ctrl.arf_out_d_sel = c_arf_out_ar;
              w_ctrl.mem_cs        = 1'b0;
              w_ctrl.dr_e          = 1'b1;
              w_ctrl.dr_fun_sel    = c_dr_fun_clr_ll;
            end
            c_op_st: begin
              w_ctrl.rf_out_a_sel  = {1'b0, w_rsel};
              w_ctrl.mux_d_sel     = 1'b0;
              w_ctrl.alu_fun_sel   = c_alu_passa;
              w_ctrl.mux_c_sel     = c_muxc_alu;
              w_ctrl.arf_out_d_sel = c_arf_out_ar;
              w_ctrl.mem_cs        = 1'b0;
              w_ctrl.mem_wr        = 1'b1;
            end
            default: w_ctrl = c_idle;
          endcase
        end
        ST_T3: begin
          // Second half of LD: write the fetched data register into Rx.
          if (w_opcode == c_op_ld) begin
            w_ctrl.mux_a_sel  = c_muxa_dr;
            w_ctrl.rf_reg_sel = rf_onehot(w_rsel);
            w_ctrl.rf_fun_sel = c_rf_fun_load;
          end
        end
        default: w_ctrl = c_idle;
      endcase
    end
  end

  assign bus.T           = w_state;
  assign bus.ALU_WF      = w_ctrl.alu_wf;
  assign bus.ALU_FunSel  = w_ctrl.alu_fun_sel;
  assign bus.RF_OutASel  = w_ctrl.rf_out_a_sel;
  assign bus.RF_OutBSel  = w_ctrl.rf_out_b_sel;
  assign bus.RF_FunSel   = w_ctrl.rf_fun_sel;
  assign bus.RF_RegSel   = w_ctrl.rf_reg_sel;
  assign bus.RF_ScrSel   = w_ctrl.rf_scr_sel;
  assign bus.ARF_OutCSel = w_ctrl.arf_out_c_sel;
  assign bus.ARF_OutDSel = w_ctrl.arf_out_d_sel;
  assign bus.ARF_FunSel  = w_ctrl.arf_fun_sel;
  assign bus.ARF_RegSel  = w_ctrl.arf_reg_sel;
  assign bus.IR_Write    = w_ctrl.ir_write;
  assign bus.IR_LH       = w_ctrl.ir_lh;
  assign bus.Mem_CS      = w_ctrl.mem_cs;
  assign bus.Mem_WR      = w_ctrl.mem_wr;
  assign bus.DR_E        = w_ctrl.dr_e;
  assign bus.DR_FunSel   = w_ctrl.dr_fun_sel;
  assign bus.MuxASel     = w_ctrl.mux_a_sel;
  assign bus.MuxBSel     = w_ctrl.mux_b_sel;
  assign bus.MuxCSel     = w_ctrl.mux_c_sel;
  assign bus.MuxDSel     = w_ctrl.mux_d_sel;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ------------------------------------------------------------------
// tb_control_unit : directed self-checking bench for control_unit
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_control_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  control_unit_if cu_if();

  control_unit dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (cu_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starting in T0: load IR/flags, then advance through T1 into T2.
  task automatic to_t2(input logic [15:0] ir, input logic [3:0] fl);
    cu_if.IROut = ir;
    cu_if.Flags = fl;
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cu_if.IROut = 16'h0000;
    cu_if.Flags = 4'h0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_T",        32'(cu_if.T),          32'h1);
    check("rst_MemCS",    32'(cu_if.Mem_CS),     32'h1);
    check("rst_IRWrite",  32'(cu_if.IR_Write),   32'h0);
    check("rst_ARFReg",   32'(cu_if.ARF_RegSel), 32'h0);
    check("rst_RFReg",    32'(cu_if.RF_RegSel),  32'h0);

    rst = 1'b0;
    #1;
    check("t0_IRWrite",   32'(cu_if.IR_Write),    32'h1);
    check("t0_IRLH",      32'(cu_if.IR_LH),       32'h0);
    check("t0_ARFReg",    32'(cu_if.ARF_RegSel),  32'h4);
    check("t0_ARFFun",    32'(cu_if.ARF_FunSel),  32'h1);
    check("t0_MemCS",     32'(cu_if.Mem_CS),      32'h0);
    check("t0_OutD",      32'(cu_if.ARF_OutDSel), 32'h0);

    // MOVL R1,5 with the T1 fetch checked on the way
    cu_if.IROut = 16'h0C05;
    tick();
    check("t1_T",         32'(cu_if.T),          32'h2);
    check("t1_IRLH",      32'(cu_if.IR_LH),      32'h1);
    check("t1_IRWrite",   32'(cu_if.IR_Write),   32'h1);
    check("t1_ARFFun",    32'(cu_if.ARF_FunSel), 32'h1);
    tick();
    check("movl_T",       32'(cu_if.T),          32'h4);
    check("movl_RFReg",   32'(cu_if.RF_RegSel),  32'h8);
    check("movl_RFFun",   32'(cu_if.RF_FunSel),  32'h2);
    check("movl_MuxA",    32'(cu_if.MuxASel),    32'h3);
    check("movl_MemCS",   32'(cu_if.Mem_CS),     32'h1);
    tick();
    check("movl_next_T",  32'(cu_if.T),          32'h1);

    // ADD R3 <- R1 + R2
    to_t2(16'h11A5, 4'h0);
    check("add_OutA",     32'(cu_if.RF_OutASel), 32'h0);
    check("add_OutB",     32'(cu_if.RF_OutBSel), 32'h1);
    check("add_Fun",      32'(cu_if.ALU_FunSel), 32'h04);
    check("add_WF",       32'(cu_if.ALU_WF),     32'h1);
    check("add_RFReg",    32'(cu_if.RF_RegSel),  32'h2);
    check("add_MuxA",     32'(cu_if.MuxASel),    32'h0);
    tick();

    // SUB R4 <- R3 - R1
    to_t2(16'h15F4, 4'h0);
    check("sub_Fun",      32'(cu_if.ALU_FunSel), 32'h06);
    check("sub_OutA",     32'(cu_if.RF_OutASel), 32'h2);
    check("sub_OutB",     32'(cu_if.RF_OutBSel), 32'h0);
    check("sub_RFReg",    32'(cu_if.RF_RegSel),  32'h1);
    tick();

    // AND with the same register fields
    to_t2(16'h19F4, 4'h0);
    check("and_Fun",      32'(cu_if.ALU_FunSel), 32'h07);
    check("and_RFFun",    32'(cu_if.RF_FunSel),  32'h2);
    tick();

    // ADD with DST=000 is a NOP
    to_t2(16'h1025, 4'h0);
    check("nop_RFReg",    32'(cu_if.RF_RegSel),  32'h0);
    check("nop_WF",       32'(cu_if.ALU_WF),     32'h0);
    tick();
    check("nop_next_T",   32'(cu_if.T),          32'h1);

    // BEQ taken and not taken
    to_t2(16'h0840, 4'h8);
    check("beqz1_ARFReg", 32'(cu_if.ARF_RegSel), 32'h4);
    check("beqz1_ARFFun", 32'(cu_if.ARF_FunSel), 32'h2);
    check("beqz1_MuxB",   32'(cu_if.MuxBSel),    32'h3);
    tick();
    to_t2(16'h0840, 4'h7);
    check("beqz0_ARFReg", 32'(cu_if.ARF_RegSel), 32'h0);
    check("beqz0_MuxB",   32'(cu_if.MuxBSel),    32'h0);
    tick();

    // BNE taken with Z=0
    to_t2(16'h0440, 4'h0);
    check("bne_ARFReg",   32'(cu_if.ARF_RegSel), 32'h4);
    tick();

    // ST R2
    to_t2(16'h2100, 4'h0);
    check("st_MemWR",     32'(cu_if.Mem_WR),      32'h1);
    check("st_MemCS",     32'(cu_if.Mem_CS),      32'h0);
    check("st_OutD",      32'(cu_if.ARF_OutDSel), 32'h2);
    check("st_OutA",      32'(cu_if.RF_OutASel),  32'h1);
    tick();
    check("st_next_T",    32'(cu_if.T),           32'h1);

    // LD R2: four-cycle instruction
    to_t2(16'h1D00, 4'h0);
    check("ld_DRE",       32'(cu_if.DR_E),        32'h1);
    check("ld_DRFun",     32'(cu_if.DR_FunSel),   32'h1);
    check("ld_OutD",      32'(cu_if.ARF_OutDSel), 32'h2);
    check("ld_MemCS",     32'(cu_if.Mem_CS),      32'h0);
    tick();
    check("ld_T3",        32'(cu_if.T),           32'h8);
    check("ld_MuxA",      32'(cu_if.MuxASel),     32'h2);
    check("ld_RFReg",     32'(cu_if.RF_RegSel),   32'h4);
    tick();
    check("ld_next_T",    32'(cu_if.T),           32'h1);

    // LD interrupted by Reset in T3
    to_t2(16'h1D00, 4'h0);
    tick();
    check("ldr_T3",       32'(cu_if.T),           32'h8);
    rst = 1'b1;
    #1;
    check("ldr_RFReg",    32'(cu_if.RF_RegSel),   32'h0);
    check("ldr_MuxA",     32'(cu_if.MuxASel),     32'h0);
    tick();
    check("ldr_T",        32'(cu_if.T),           32'h1);
    rst = 1'b0;

    // Undefined opcode: idle T2, back to T0
    to_t2(16'hFC00, 4'hF);
    check("undef_T",      32'(cu_if.T),           32'h4);
    check("undef_MemCS",  32'(cu_if.Mem_CS),      32'h1);
    check("undef_ARFReg", 32'(cu_if.ARF_RegSel),  32'h0);
    tick();
    check("undef_next_T", 32'(cu_if.T),           32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/control_unit.md
# control_unit

Hardwired control unit that sits directly upstream of the ALU/register/memory datapath and generates every one of its control inputs each cycle. It runs the sequence fetch (two byte reads into IR), then decode, then execute. It observes IROut and the ALU flags. A sequence counter T0–T3 drives it, and the counter returns to T0 at the end of each instruction.

## Interface
- Parameters: none.
- Clock  input  1  system clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-high; clears state; outputs idle while high.
- IROut  input  16  instruction from IR; stable from T2 onward.
- Flags  input  4  {Z,C,N,O} from ALU flag register; Z = Flags[3].
- T  output  4  one-hot sequence state (T0 = 4'b0001).
- ALU_WF  output  1 / ALU_FunSel  output  5  ALU flag write and function select.
- RF_OutASel, RF_OutBSel  output  3 each / RF_FunSel  output  3  register file read selects and function.
- RF_RegSel, RF_ScrSel  output  4 each  register file write enables (1 = enabled, bit3 = R1/S1).
- ARF_OutCSel, ARF_OutDSel, ARF_FunSel  output  2 each / ARF_RegSel  output  3  (bit2 PC, bit1 SP, bit0 AR; 1 = enabled).
- IR_Write, IR_LH  output  1 each  IR load and byte select (0 = low byte).
- Mem_CS, Mem_WR  output  1 each  chip select is active-low; WR: 1 = write.
- DR_E  output  1 / DR_FunSel  output  2  data register enable and function.
- MuxASel, MuxBSel, MuxCSel  output  2 each / MuxDSel  output  1.

## Operation
- Idle vector: all enables 0, Mem_CS=1, Mem_WR=0, all selects and FunSels 0. This vector is driven in Reset and in any cycle not listed below.
- Encodings:
  - RF FunSel and ARF FunSel: 010 / 10 = load, 01 = increment.
  - ARF_OutDSel: 00 = PC, 10 = AR.
  - DR_FunSel 01 = clear and load low byte.
  - ALU codes: PASSA=5'b00000, ADD=5'b00100, SUB=5'b00110, AND=5'b00111.
- T0: ARF_OutDSel=00, Mem_CS=0, IR_Write=1, IR_LH=0, ARF_RegSel=100, ARF_FunSel=01.
- T1: same as T0 but IR_LH=1, so IR = {M[PC+1], M[PC]}.
- Instruction fields:
  - opcode = IROut[15:10]; RSel = IROut[9:8] (00 = R1 … 11 = R4); VALUE = IROut[7:0].
  - DST = IROut[8:6], S1 = IROut[5:3], S2 = IROut[2:0]. Valid codes are 1xx (R1–R4); the RF read select is {1'b0, code[1:0]}.
- T2 execution by opcode:
  - 0x00 BRA: MuxBSel=11, ARF_RegSel=100, ARF_FunSel=10.
  - 0x01 BNE / 0x02 BEQ: same as BRA, only when Z=0 / Z=1; otherwise the idle vector.
  - 0x03 MOVL: MuxASel=11, RF_RegSel=onehot(RSel), RF_FunSel=010.
  - 0x04/0x05/0x06 ADD/SUB/AND: RF_OutASel=S1, RF_OutBSel=S2, MuxDSel=0, ALU_FunSel=op, ALU_WF=1, MuxASel=00, RF_RegSel=onehot(DST), RF_FunSel=010.
  - 0x07 LD: ARF_OutDSel=10, Mem_CS=0, DR_E=1, DR_FunSel=01.
  - 0x08 ST: RF_OutASel=RSel, MuxDSel=0, ALU_FunSel=PASSA, MuxCSel=00, ARF_OutDSel=10, Mem_CS=0, Mem_WR=1.
  - Any DST/S1/S2 code of 0xx, or any other opcode: NOP (idle vector).
- T3 (LD only): MuxASel=10, RF_RegSel=onehot(RSel), RF_FunSel=010.
- Sequencing: T0→T1→T2. From T2, go to T3 if opcode=LD, else T0. T3→T0.

## Timing
- Reset value: T=0001 and the idle vector on every output; reset takes priority over advance.
- Outputs are combinational from T, IROut and Flags (Moore-style per state). No output is registered.
- Instruction latency:
  - 3 cycles for all opcodes except LD, which takes 4.
  - IR is complete after the T1 edge. PC is incremented twice during fetch.
- Branch: the condition samples Flags during T2. PC loads at the end of T2. A flag write in the same cycle has no effect.
- Reset asserted mid-instruction: the next edge forces T0. No partial write is issued while Reset is high.
- No overflow or wrap: T is a one-hot state, and any non-one-hot value recovers to T0 on the next edge.

## Structure
- Package cpu_ctrl_pkg: opcode constants, ALU codes, FunSel codes, ARF/RF select constants, and the idle-vector defaults.
- Sub-module sequence_counter: one-hot T register with synchronous clear (Reset or end-of-instruction) and advance.

## Test plan
- Reset held 2 cycles, then released → T=0001, Mem_CS=1, all enables 0; next edge T=0010.
- Fetch → T0: IR_Write=1, IR_LH=0, ARF_RegSel=100, ARF_FunSel=01; T1: IR_LH=1.
- IROut=0x0C05 (MOVL R1,5) → T2: RF_RegSel=1000, RF_FunSel=010, MuxASel=11; next T=0001.
- IROut=0x11A5 (ADD R3←R1+R2) → T2: OutASel=000, OutBSel=001, ALU_FunSel=00100, ALU_WF=1, RF_RegSel=0010.
- IROut=0x0840 (BEQ 0x40):
  - Z=1 → ARF_RegSel=100, ARF_FunSel=10, MuxBSel=11.
  - Z=0 → ARF_RegSel=000.
- IROut=0x1D00 (LD R2) → T2: DR_E=1, ARF_OutDSel=10; T3: MuxASel=10, RF_RegSel=0100. Reset asserted in T3 → next T=0001, no RF write.
